// File: rtl/cmd_saver.sv
// cmd_saver: serialises a RAM region into a TRS-80 /CMD image (type-01 load records, then a type-02 transfer record)
module cmd_saver #(
  parameter int RAM_LAT = 2,
  parameter int MAX_BLK = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] exec_addr,
  output logic        ram_rd,
  output logic [15:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_wait,
  output logic [23:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, REC_HDR, RD_REQ, RD_WAIT, DATA, XFER, FIN} state_t;
  state_t      state;
  logic [15:0] cur, exec_l;
  logic [16:0] rem;
  logic [8:0]  blk, blk_n;
  logic [1:0]  idx;
  logic [2:0]  lat;
  logic        acc;
  logic [7:0]  hdr_b, xfr_b;
  // hdr_b/xfr_b are the bytes that follow position idx within the current record
  always_comb begin
    acc   = out_valid && !out_wait;
    blk_n = (rem >= 17'(MAX_BLK)) ? 9'(MAX_BLK) : rem[8:0];
    hdr_b = (idx == 2'd0) ? blk_n[7:0] + 8'd2 : (idx == 2'd1) ? cur[7:0] : cur[15:8];
    xfr_b = (idx == 2'd0) ? 8'h02 : (idx == 2'd1) ? exec_l[7:0] : exec_l[15:8];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur       <= '0;
      exec_l    <= '0;
      rem       <= '0;
      blk       <= '0;
      idx       <= '0;
      lat       <= '0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done   <= 1'b0;
      ram_rd <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (end_addr < start_addr) error <= 1'b1;
          else begin
            error     <= 1'b0;
            cur       <= start_addr;
            exec_l    <= exec_addr;
            rem       <= 17'(end_addr) - 17'(start_addr) + 17'd1;
            out_addr  <= '0;
            busy      <= 1'b1;
            idx       <= '0;
            out_data  <= 8'h01;
            out_valid <= 1'b1;
            state     <= REC_HDR;
          end
        end
        REC_HDR: if (acc) begin
          out_addr <= out_addr + 24'd1;
          if (idx == 2'd3) begin
            out_valid <= 1'b0;
            blk       <= blk_n;
            state     <= RD_REQ;
          end else begin
            idx      <= idx + 2'd1;
            out_data <= hdr_b;
          end
        end
        RD_REQ: begin
          ram_rd   <= 1'b1;
          ram_addr <= cur;
          lat      <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: if (lat == 3'(RAM_LAT)) begin
          out_data  <= ram_data;
          out_valid <= 1'b1;
          state     <= DATA;
        end else lat <= lat + 3'd1;
        DATA: if (acc) begin
          out_addr <= out_addr + 24'd1;
          cur      <= cur + 16'd1;
          rem      <= rem - 17'd1;
          blk      <= blk - 9'd1;
          idx      <= '0;
          if (blk != 9'd1) begin
            out_valid <= 1'b0;
            state     <= RD_REQ;
          end else if (rem != 17'd1) begin
            out_data <= 8'h01;
            state    <= REC_HDR;
          end else begin
            out_data <= 8'h02;
            state    <= XFER;
          end
        end
        XFER: if (acc) begin
          out_addr <= out_addr + 24'd1;
          if (idx == 2'd3) begin
            out_valid <= 1'b0;
            state     <= FIN;
          end else begin
            idx      <= idx + 2'd1;
            out_data <= xfr_b;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_saver.sv
// tb_cmd_saver: directed and random saves checked against a byte-stream model built from the /CMD format rules
module tb_cmd_saver;
  localparam int RAM_LAT = 2;
  logic        clock = 0, reset_n = 0, start = 0, out_wait = 0;
  logic [15:0] start_addr = 0, end_addr = 0, exec_addr = 0;
  logic [7:0]  ram_data = 0;
  logic        ram_rd, out_valid, busy, done, error;
  logic [15:0] ram_addr;
  logic [7:0]  out_data;
  logic [23:0] out_addr;
  int errors = 0, checks = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] pipe [0:RAM_LAT-1];
  byte unsigned exp_q[$], cap_d[$];
  int cap_a[$];
  int done_cnt = 0, rd_cnt = 0, hold_viol = 0, valid_cnt = 0;
  bit rnd_wait = 0;

  always #5 clock = ~clock;

  cmd_saver #(.RAM_LAT(RAM_LAT), .MAX_BLK(256)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .exec_addr(exec_addr), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_data(ram_data), .out_data(out_data), .out_valid(out_valid), .out_wait(out_wait),
    .out_addr(out_addr), .busy(busy), .done(done), .error(error)
  );

  initial forever begin
    @(posedge clock);
    #1 out_wait = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // RAM returns the addressed byte exactly RAM_LAT cycles after the read strobe, noise otherwise
  initial forever begin
    @(negedge clock);
    ram_data = pipe[RAM_LAT-1];
    for (int i = RAM_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = ram_rd ? mem[ram_addr] : 8'($urandom);
  end

  initial begin
    logic       ph;
    logic [7:0] pd;
    logic [23:0] pa;
    ph = 0; pd = 0; pa = 0;
    forever begin
      @(negedge clock);
      if (ph && (!out_valid || out_data !== pd || out_addr !== pa)) hold_viol++;
      ph = out_valid && out_wait;
      pd = out_data;
      pa = out_addr;
      if (out_valid) valid_cnt++;
      if (out_valid && !out_wait) begin
        cap_d.push_back(out_data);
        cap_a.push_back(int'(out_addr));
      end
      if (done) done_cnt++;
      if (ram_rd) rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int sa, input int ea, input int ex);
    int a, rem, b;
    a = sa;
    rem = ea - sa + 1;
    exp_q.delete();
    while (rem > 0) begin
      b = (rem > 256) ? 256 : rem;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'((b + 2) % 256));
      exp_q.push_back(8'(a % 256));
      exp_q.push_back(8'(a / 256));
      for (int i = 0; i < b; i++) begin
        exp_q.push_back(mem[16'(a)]);
        a = (a + 1) % 65536;
      end
      rem -= b;
    end
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'(ex % 256));
    exp_q.push_back(8'(ex / 256));
  endtask

  task automatic do_save(input logic [15:0] sa, input logic [15:0] ea, input logic [15:0] ex, input bit rw);
    int n, lim, nbad, nbad_a, fb;
    bit got;
    n = int'(ea) - int'(sa) + 1;
    build_exp(int'(sa), int'(ea), int'(ex));
    rnd_wait = rw;
    @(posedge clock);
    #1 start_addr = sa; end_addr = ea; exec_addr = ex; start = 1;
    cap_d.delete(); cap_a.delete();
    done_cnt = 0; rd_cnt = 0; hold_viol = 0;
    @(posedge clock);
    #1 start = 0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    if (n > 16) begin
      repeat (20) @(posedge clock);
      #1 start_addr = 16'($urandom); end_addr = 16'hFFFF; exec_addr = 16'($urandom); start = 1;
      @(posedge clock);
      #1 start = 0;
    end
    lim = 20 * exp_q.size() + 200;
    got = 0;
    for (int c = 0; c < lim && !got; c++) begin
      @(negedge clock);
      got = done_cnt > 0;
    end
    check("done_seen", got, 1);
    repeat (5) @(negedge clock);
    rnd_wait = 0;
    check("done_once", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("stream_len", cap_d.size(), exp_q.size());
    check("ram_reads", rd_cnt, n);
    check("hold_stable", hold_viol, 0);
    nbad = 0; nbad_a = 0; fb = -1;
    for (int i = 0; i < cap_d.size() && i < exp_q.size(); i++) begin
      if (cap_d[i] !== exp_q[i]) begin
        nbad++;
        if (fb < 0) fb = i;
      end
      if (cap_a[i] != i) nbad_a++;
    end
    check("stream_mismatches", nbad, 0);
    if (fb >= 0) check("first_bad_byte", cap_d[fb], exp_q[fb]);
    check("addr_seq_errs", nbad_a, 0);
    if (cap_a.size() > 0) check("last_out_addr", cap_a[cap_a.size()-1], exp_q.size() - 1);
  endtask

  initial begin
    bit got;
    int sa, len;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (2) @(posedge clock);
    #1 check("reset_outputs", {ram_rd, ram_addr, out_data, out_valid, out_addr, busy, done, error}, 0);
    reset_n = 1;

    for (int i = 0; i < 256; i++) mem[16'h5200 + i] = 8'(i);
    do_save(16'h5200, 16'h52FF, 16'h5200, 0);
    check("len_264", cap_d.size(), 264);
    do_save(16'h6000, 16'h6101, 16'h6010, 0);
    check("len_270", cap_d.size(), 270);
    check("rec2_len_byte", cap_d[261], 8'h04);
    do_save(16'h6000, 16'h6101, 16'h6010, 1);
    do_save(16'h1000, 16'h10FD, 16'h1234, 0);
    check("len254_byte", cap_d[1], 8'h00);

    @(posedge clock);
    #1 start_addr = 16'h8000; end_addr = 16'h7FFF; exec_addr = 16'h8000; start = 1;
    valid_cnt = 0;
    @(posedge clock);
    #1 start = 0;
    repeat (10) @(negedge clock);
    check("error_set", error, 1);
    check("error_busy", busy, 0);
    check("error_no_valid", valid_cnt, 0);
    mem[16'h7000] = 8'hA5;
    do_save(16'h7000, 16'h7000, 16'h7000, 0);
    check("len_9", cap_d.size(), 9);

    @(posedge clock);
    #1 start_addr = 16'h5200; end_addr = 16'h52FF; exec_addr = 16'h5200; start = 1;
    done_cnt = 0; cap_d.delete(); cap_a.delete();
    @(posedge clock);
    #1 start = 0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clock);
      got = cap_d.size() >= 12;
    end
    check("reached_data_phase", got, 1);
    #2 reset_n = 0;
    #1 check("async_reset_outputs", {ram_rd, ram_addr, out_data, out_valid, out_addr, busy, done, error}, 0);
    repeat (3) @(negedge clock);
    check("no_done_after_reset", done_cnt, 0);
    @(posedge clock);
    #1 reset_n = 1;
    do_save(16'h5200, 16'h52FF, 16'h5200, 0);

    repeat (3) begin
      sa = $urandom_range(0, 16'hF000);
      len = $urandom_range(1, 600);
      do_save(16'(sa), 16'(sa + len - 1), 16'($urandom), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_saver.md
Name: cmd_saver

Overview:
- Writer counterpart to the CMD loader: serialises a region of TRS-80 RAM into a TRS-80 /CMD image and streams it out byte by byte.
- Sits between the trs80 memory port and the HPS upload path.
- Emits one or more type-01 load records of at most 256 bytes each, then one type-02 transfer record.
- Reading the resulting file back through the CMD loader must restore the same RAM contents and the same entry point.

Parameters:
RAM_LAT, 2, cycles from ram_rd pulse to valid ram_data (1..4)
MAX_BLK, 256, maximum data bytes per load record (fixed 256; the length encoding relies on it)

Ports:
clock  in  1  system clock (42 MHz clk_sys)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin save; ignored unless idle
start_addr  in  16  first RAM address to save
end_addr  in  16  last RAM address to save (inclusive)
exec_addr  in  16  transfer address written in the type-02 record
ram_rd  out  1  one-cycle read strobe
ram_addr  out  16  read address, stable from the ram_rd cycle until data is captured
ram_data  in  8  read data, valid exactly RAM_LAT cycles after ram_rd
out_data  out  8  output byte
out_valid  out  1  out_data valid
out_wait  in  1  sink backpressure; a byte transfers on a cycle with out_valid=1 and out_wait=0
out_addr  out  24  byte offset of out_data within the file
busy  out  1  save in progress
done  out  1  one-cycle pulse after the last byte is accepted
error  out  1  sticky: set when start is seen with end_addr<start_addr; cleared by the next accepted start

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0: ram_rd, ram_addr, out_data, out_valid, out_addr, busy, done, error.
  - Internal counters cleared.
- IDLE, start=1:
  - If end_addr<start_addr: set error, stay IDLE, emit no bytes.
  - Otherwise: clear error, latch all three addresses, set remaining = end_addr-start_addr+1 (17 bits, range 1..65536), cur = start_addr, out_addr = 0, busy = 1, go to REC_HDR.
- start while busy: ignored. Latched addresses are not re-sampled.
- REC_HDR: n = min(remaining, 256). Emit 4 bytes in order:
  - 0x01
  - (n+2) mod 256 (n=256 gives 0x02; n=254 gives 0x00)
  - cur[7:0]
  - cur[15:8]
  - Then go to RD_REQ.
- RD_REQ: pulse ram_rd with ram_addr=cur, go to RD_WAIT.
- RD_WAIT: count RAM_LAT cycles, capture ram_data into out_data, go to DATA.
- DATA: hold out_valid until the byte is accepted. On accept:
  - cur wraps at 16 bits; remaining and the in-block count decrement.
  - If the block is not finished: go to RD_REQ.
  - Else if remaining > 0: go to REC_HDR.
  - Else: go to XFER.
- XFER: emit 0x02, 0x02, exec_addr[7:0], exec_addr[15:8], then go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Output handshake:
  - out_valid rises with out_data already set.
  - While out_wait=1, out_data and out_addr stay stable and out_valid stays 1.
  - out_addr increments by 1 on each accept.
  - At most one byte per cycle; back-to-back accepts are allowed inside header and transfer records.
  - Data bytes incur at least RAM_LAT+1 idle cycles each.
- Total file length = 4*ceil(N/256) + N + 4, where N = byte count. N=65536 gives 256 records and 66564 bytes; out_addr is 24 bits to cover this.
- Reset mid-save: immediate return to IDLE with every output at its reset value. No partial done.
- ram_rd is never issued while a data byte is waiting for acceptance: only one read is in flight.

Test Plan:
- start=0x5200, end=0x52FF, exec=0x5200, RAM[a]=a[7:0], out_wait=0 → 264 bytes: 01 02 00 52, 00..FF, 02 02 00 52; done once; final out_addr=263.
- start=0x6000, end=0x6101 (258 bytes), exec=0x6010 → first record 01 02 00 60 plus 256 data; second record 01 04 00 61 plus 2 data; then 02 02 10 60; total 270 bytes.
- Single byte: start=end=0x7000, RAM=0xA5 → 01 03 00 70 A5 02 02 00 70; 9 bytes.
- Random out_wait (50% duty) on the 258-byte case → identical byte stream and out_addr sequence; out_data never changes while out_wait=1.
- start=0x8000, end=0x7FFF → error=1, busy stays 0, no out_valid. A following valid start clears error.
- reset_n low during the data phase of a 0x5200–0x52FF save → all outputs 0 asynchronously, no done pulse. A fresh start afterwards produces the full 264-byte stream.
